// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the ultrasonic ranging blocks.
// Holds the filter FSM state encoding and the default conversion and
// threshold constants, so every block agrees on the same numbers.
package ultrasonido_pkg;

  // Echo ticks (1 us each) per centimetre of distance.
  localparam int TICKS_POR_CM_DEF = 58;
  // Saturation value for converted distance, in cm.
  localparam int DIST_MAX_DEF     = 400;
  // Proximity thresholds, in cm (UMBRAL_OFF must be >= UMBRAL_ON).
  localparam int UMBRAL_ON_DEF    = 50;
  localparam int UMBRAL_OFF_DEF   = 60;

  // Widths of the converted distance and of the 4-sample running sum.
  localparam int ANCHO_DIST = 9;
  localparam int ANCHO_SUMA = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVIDE  = 2'd1,
    AVERAGE = 2'd2,
    OUTPUT  = 2'd3
  } estado_t;

endpackage

// File: rtl/divisor_serial.sv
// Repeated-subtraction divider with saturation.
// A start pulse loads the dividend and clears the quotient; each following
// cycle subtracts DIVISOR while the remainder allows it and the quotient is
// below the limit. done is high for the single cycle in which no further
// subtraction is possible, so a conversion to quotient q takes q+1 cycles.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              load dividend and begin
//   dividend [15:0]    value to divide (sampled on start)
//   limit    [8:0]     saturation limit for the quotient
//   done               one-cycle pulse, quotient is final
//   quotient [8:0]     min(floor(dividend/DIVISOR), limit)
module divisor_serial
  import ultrasonido_pkg::*;
#(
  parameter int DIVISOR = TICKS_POR_CM_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           dividend,
  input  logic [ANCHO_DIST-1:0] limit,
  output logic                  done,
  output logic [ANCHO_DIST-1:0] quotient
);

  logic [15:0] resto;
  logic        activo;
  logic        paso;

  // A subtraction is still due only while both the remainder and the
  // saturation limit allow it; otherwise the result is final.
  assign paso = (resto >= 16'(DIVISOR)) && (quotient < limit);
  assign done = activo && !paso;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resto    <= '0;
      quotient <= '0;
      activo   <= 1'b0;
    end else if (start) begin
      resto    <= dividend;
      quotient <= '0;
      activo   <= 1'b1;
    end else if (activo) begin
      if (paso) begin
        resto    <= resto - 16'(DIVISOR);
        quotient <= quotient + 1'b1;
      end else begin
        activo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/filtro_distancia.sv
// Converts ultrasonic echo times to centimetres, averages the last four
// distances and raises a proximity flag with hysteresis.
// Ports:
//   clk, reset_n         50 MHz clock, asynchronous active-low reset
//   med_valid            one-cycle pulse, cuenta_echo holds a measurement
//   cuenta_echo [15:0]   echo high time in 1 us ticks
//   busy                 a sample is being processed
//   distancia_cm [8:0]   4-sample moving average in cm
//   dist_valid           one-cycle pulse, distancia_cm and cerca updated
//   cerca                proximity flag with hysteresis
//   sin_eco              one-cycle pulse, sample had no echo (count 0)
//   descartes [7:0]      saturating count of samples dropped while busy
module filtro_distancia
  import ultrasonido_pkg::*;
#(
  parameter int TICKS_POR_CM = TICKS_POR_CM_DEF,
  parameter int DIST_MAX     = DIST_MAX_DEF,
  parameter int UMBRAL_ON    = UMBRAL_ON_DEF,
  parameter int UMBRAL_OFF   = UMBRAL_OFF_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  med_valid,
  input  logic [15:0]           cuenta_echo,
  output logic                  busy,
  output logic [ANCHO_DIST-1:0] distancia_cm,
  output logic                  dist_valid,
  output logic                  cerca,
  output logic                  sin_eco,
  output logic [7:0]            descartes
);

  estado_t               estado;
  logic [ANCHO_DIST-1:0] anillo [4];
  logic [ANCHO_SUMA-1:0] suma;
  logic [1:0]            ptr;
  logic [2:0]            llenos;
  logic                  arranque;
  logic                  div_done;
  logic [ANCHO_DIST-1:0] cociente;
  logic [ANCHO_DIST-1:0] promedio;

  // Only a real echo in IDLE starts a conversion; zero counts are flagged
  // and otherwise ignored.
  assign arranque = (estado == IDLE) && med_valid && (cuenta_echo != 16'd0);
  assign busy     = (estado != IDLE);
  assign promedio = suma[ANCHO_SUMA-1:2];

  divisor_serial #(
    .DIVISOR(TICKS_POR_CM)
  ) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (arranque),
    .dividend(cuenta_echo),
    .limit   (ANCHO_DIST'(DIST_MAX)),
    .done    (div_done),
    .quotient(cociente)
  );

  // Main FSM. The running sum is kept incrementally (add newest, drop the
  // entry being overwritten) so the average never needs a 4-input adder.
  // Results are published only once four samples exist since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= IDLE;
      suma         <= '0;
      ptr          <= '0;
      llenos       <= '0;
      distancia_cm <= '0;
      dist_valid   <= 1'b0;
      cerca        <= 1'b0;
      sin_eco      <= 1'b0;
      descartes    <= '0;
      for (int i = 0; i < 4; i++) anillo[i] <= '0;
    end else begin
      dist_valid <= 1'b0;
      sin_eco    <= 1'b0;

      if (med_valid && (estado != IDLE) && (descartes != 8'hFF))
        descartes <= descartes + 1'b1;

      case (estado)
        IDLE: begin
          if (med_valid) begin
            if (cuenta_echo == 16'd0) sin_eco <= 1'b1;
            else                      estado  <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done) estado <= AVERAGE;
        end
        AVERAGE: begin
          anillo[ptr] <= cociente;
          suma        <= suma + ANCHO_SUMA'(cociente) - ANCHO_SUMA'(anillo[ptr]);
          ptr         <= ptr + 1'b1;
          if (llenos != 3'd4) llenos <= llenos + 1'b1;
          estado <= OUTPUT;
        end
        OUTPUT: begin
          if (llenos == 3'd4) begin
            dist_valid   <= 1'b1;
            distancia_cm <= promedio;
            if (promedio < ANCHO_DIST'(UMBRAL_ON))        cerca <= 1'b1;
            else if (promedio >= ANCHO_DIST'(UMBRAL_OFF)) cerca <= 1'b0;
          end
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_distancia.sv
// Self-checking bench for filtro_distancia.
// A timing-level model predicts every output from the sample history and
// is compared with the DUT on each falling edge; directed sequences add
// literal checks of latency, averages, flags and drop counting.
module tb_filtro_distancia;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        med_valid = 1'b0;
  logic [15:0] cuenta_echo = '0;
  logic        busy;
  logic [8:0]  distancia_cm;
  logic        dist_valid;
  logic        cerca;
  logic        sin_eco;
  logic [7:0]  descartes;

  int total = 0;
  int bad   = 0;

  filtro_distancia dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .med_valid   (med_valid),
    .cuenta_echo (cuenta_echo),
    .busy        (busy),
    .distancia_cm(distancia_cm),
    .dist_valid  (dist_valid),
    .cerca       (cerca),
    .sin_eco     (sin_eco),
    .descartes   (descartes)
  );

  always #10 clk = ~clk;

  task automatic check_output(input string nombre, input int actual, input int esperado);
    total++;
    if (actual != esperado) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nombre, actual, esperado, $time);
    end
  endtask

  // Model: a sample accepted at edge k with quotient q is published at edge
  // k+q+3; between those edges the block is busy and any med_valid is dropped.
  int  cyc = 0;
  bit  m_pend = 0;
  int  m_out = 0;
  int  m_q = 0;
  int  hist[$];
  int  m_count = 0;
  int  exp_dist = 0;
  bit  exp_cerca = 0;
  bit  exp_dv = 0;
  bit  exp_sin = 0;
  int  exp_desc = 0;
  bit  compare_on = 0;

  always @(posedge clk or negedge reset_n) begin : modelo
    bit ocupado;
    bit fin;
    int s;
    if (!reset_n) begin
      m_pend = 0; m_count = 0; exp_dist = 0; exp_cerca = 0;
      exp_dv = 0; exp_sin = 0; exp_desc = 0;
      hist.delete();
    end else begin
      cyc++;
      exp_dv  = 0;
      exp_sin = 0;
      ocupado = m_pend;
      fin     = m_pend && (cyc == m_out);
      if (fin) begin
        hist.push_back(m_q);
        if (hist.size() > 4) void'(hist.pop_front());
        m_count++;
        if (m_count >= 4) begin
          s = 0;
          foreach (hist[i]) s += hist[i];
          exp_dist = s / 4;
          exp_dv   = 1;
          if (exp_dist < 50)       exp_cerca = 1;
          else if (exp_dist >= 60) exp_cerca = 0;
        end
        m_pend = 0;
      end
      if (med_valid) begin
        if (ocupado) begin
          if (exp_desc < 255) exp_desc++;
        end else if (cuenta_echo == 16'd0) begin
          exp_sin = 1;
        end else begin
          m_q = int'(cuenta_echo) / 58;
          if (m_q > 400) m_q = 400;
          m_pend = 1;
          m_out  = cyc + m_q + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      check_output("cyc_dist_valid", int'(dist_valid), int'(exp_dv));
      check_output("cyc_distancia", int'(distancia_cm), exp_dist);
      check_output("cyc_cerca", int'(cerca), int'(exp_cerca));
      check_output("cyc_sin_eco", int'(sin_eco), int'(exp_sin));
      check_output("cyc_busy", int'(busy), int'(m_pend));
      check_output("cyc_descartes", int'(descartes), exp_desc);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one sample; returns 1 time unit after the edge that sampled it.
  task automatic apply_stimulus(input int c);
    @(posedge clk);
    #1;
    med_valid   = 1'b1;
    cuenta_echo = 16'(c);
    @(posedge clk);
    #1;
    med_valid = 1'b0;
  endtask

  task automatic wait_dv(output int lat);
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (dist_valid) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL dv_timeout: got no dist_valid expected pulse within 1000 cycles");
  endtask

  initial begin : estimulo
    int lat;
    int av34 [4];
    int ce34 [4];
    int av35 [4];
    av34 = '{51, 54, 57, 60};
    ce34 = '{1, 1, 1, 0};
    av35 = '{145, 230, 315, 400};

    #3 reset_n = 1'b0;
    compare_on = 1'b1;
    #1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_dist", int'(distancia_cm), 0);
    check_output("rst_dv", int'(dist_valid), 0);
    check_output("rst_cerca", int'(cerca), 0);
    check_output("rst_desc", int'(descartes), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] four samples of 49 cm");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(2842);
      if (k < 3) idle(98);
      else begin
        wait_dv(lat);
        check_output("s49_latency", lat, 52);
        check_output("s49_dist", int'(distancia_cm), 49);
        check_output("s49_cerca", int'(cerca), 1);
      end
    end
    idle(40);

    $display("[TB] four samples of 60 cm, hysteresis");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3480);
      wait_dv(lat);
      check_output("s60_latency", lat, 63);
      check_output("s60_dist", int'(distancia_cm), av34[k]);
      check_output("s60_cerca", int'(cerca), ce34[k]);
      idle(30);
    end

    $display("[TB] saturated echoes");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(65535);
      wait_dv(lat);
      check_output("sat_latency", lat, 403);
      check_output("sat_dist", int'(distancia_cm), av35[k]);
      idle(10);
    end

    $display("[TB] zero echo");
    apply_stimulus(0);
    check_output("noecho_pulse", int'(sin_eco), 1);
    check_output("noecho_busy", int'(busy), 0);
    idle(1);
    check_output("noecho_end", int'(sin_eco), 0);
    check_output("noecho_dist", int'(distancia_cm), 400);
    idle(5);

    $display("[TB] dropped samples");
    apply_stimulus(2842);
    idle(8);
    apply_stimulus(2842);
    check_output("drop_one", int'(descartes), 1);
    wait_dv(lat);
    check_output("drop_latency", lat, 42);
    check_output("drop_dist", int'(distancia_cm), 312);
    @(posedge clk);
    #1;
    med_valid   = 1'b1;
    cuenta_echo = 16'd65535;
    repeat (301) begin
      @(posedge clk);
      #1;
    end
    med_valid = 1'b0;
    check_output("drop_sat", int'(descartes), 255);
    wait_dv(lat);
    check_output("drop_sat_dist", int'(distancia_cm), 312);
    idle(5);

    $display("[TB] reset during divide");
    apply_stimulus(2842);
    idle(10);
    reset_n = 1'b0;
    #1;
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_dist", int'(distancia_cm), 0);
    check_output("midrst_desc", int'(descartes), 0);
    check_output("midrst_dv", int'(dist_valid), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(60);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1160);
      if (k < 3) idle(30);
      else begin
        wait_dv(lat);
        check_output("after_rst_latency", lat, 23);
        check_output("after_rst_dist", int'(distancia_cm), 20);
        check_output("after_rst_cerca", int'(cerca), 1);
      end
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
